// File: rtl/eval_scheduler_pkg.sv
// Shared types and helpers for the RTLola event-evaluation scheduler.
// Holds the FSM state type, default sizes and a saturating increment.
package eval_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    WAIT_DATA,
    EVAL,
    DONE
  } eval_state_t;

  localparam int DATA_W_DEF     = 64;
  localparam int NUM_LAYERS_DEF = 3;

  // Callers must keep counter widths at or below 32 bits.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] max);
    return (val >= max) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/eval_layer_seq.sv
// Layer sequencer: steps a layer counter once per advance and decodes it
// to a one-hot strobe. The strobe is quiet until start and after the last layer.
module eval_layer_seq
  import eval_sched_pkg::*;
#(
  parameter int NUM_LAYERS = NUM_LAYERS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  adv,
  output logic                  last,
  output logic [NUM_LAYERS-1:0] layer_en
);

  localparam int CW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam logic [NUM_LAYERS-1:0] ONE = NUM_LAYERS'(1);

  logic [CW-1:0] cnt;
  logic          active;

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      cnt    <= '0;
      active <= 1'b1;
    end else if (active && adv) begin
      if (last) active <= 1'b0;
      else      cnt    <= cnt + 1'b1;
    end
  end

  assign last     = active && (cnt == CW'(NUM_LAYERS - 1));
  assign layer_en = active ? (ONE << cnt) : '0;

endmodule

// File: rtl/eval_scheduler.sv
// Pops one event from the queue, holds it, and steps the evaluation layers in
// order. Statistics counters are built only when EVAL_STATS_EN is defined.
module eval_scheduler
  import eval_sched_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int NUM_LAYERS = NUM_LAYERS_DEF
`ifdef EVAL_STATS_EN
  , parameter int CNT_W    = 16
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  output logic                     q_pop,
  input  logic                     q_pop_valid,
  input  logic signed [DATA_W-1:0] q_data,
  input  logic                     layer_stall,
  output logic [NUM_LAYERS-1:0]    layer_en,
  output logic signed [DATA_W-1:0] event_data,
  output logic                     event_valid,
  output logic                     eval_done,
  output logic                     busy
`ifdef EVAL_STATS_EN
  , output logic [CNT_W-1:0]       stat_events,
  output logic [CNT_W-1:0]         stat_empty_polls
`endif
);

  eval_state_t state;
  logic        start;
  logic        adv;
  logic        last;

  // The queue answers regardless of en, so capture must not depend on it.
  assign start = (state == WAIT_DATA) && q_pop_valid;
  assign adv   = (state == EVAL) && en && !layer_stall;

  eval_layer_seq #(.NUM_LAYERS(NUM_LAYERS)) u_layer_seq (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .adv      (adv),
    .last     (last),
    .layer_en (layer_en)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      event_data  <= '0;
      event_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE:      if (en) state <= POP;
        POP:       if (en) state <= WAIT_DATA;
        WAIT_DATA: begin
          if (q_pop_valid) begin
            event_data  <= q_data;
            event_valid <= 1'b1;
            state       <= EVAL;
          end else begin
            state <= IDLE;
          end
        end
        EVAL:      if (adv && last) state <= DONE;
        DONE: begin
          if (en) begin
            event_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default:   state <= IDLE;
      endcase
    end
  end

  // Gating the pulses with en keeps a frozen POP from re-popping every cycle.
  assign q_pop     = (state == POP) && en;
  assign eval_done = (state == DONE) && en;
  assign busy      = (state != IDLE);

`ifdef EVAL_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_events      <= '0;
      stat_empty_polls <= '0;
    end else begin
      if ((state == WAIT_DATA) && !q_pop_valid)
        stat_empty_polls <= CNT_W'(sat_inc(32'(stat_empty_polls), 32'(CNT_MAX)));
      if ((state == DONE) && en)
        stat_events <= CNT_W'(sat_inc(32'(stat_events), 32'(CNT_MAX)));
    end
  end
`endif

endmodule

// File: doc/eval_scheduler.md
Name: eval_scheduler

Overview:
- Downstream consumer of the 5-entry 64-bit event queue.
- Pops one buffered input event, holds it stable, then steps the monitor's evaluation layers in order, one layer per cycle.
- Reports completion, then returns for the next event.
- Sits between the queue's pop side and the stream-evaluation datapath of the RTLola monitor.

Parameters:
- DATA_W, 64: width of the event word; signed, matches the queue data.
- NUM_LAYERS, 3: number of evaluation layers stepped per event; legal range 1..8.
- CNT_W, 16: width of the statistics counters (used only under EVAL_STATS_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  global enable; low freezes the FSM, except for data capture in WAIT_DATA.
- q_pop  out  1  pop request to the queue; one-cycle pulse.
- q_pop_valid  in  1  queue response: popped word valid.
- q_data  in  DATA_W  signed popped word.
- layer_stall  in  1  evaluation datapath not ready; holds the current layer.
- layer_en  out  NUM_LAYERS  one-hot strobe of the active layer.
- event_data  out  DATA_W  held copy of the current event.
- event_valid  out  1  high while event_data belongs to an in-flight evaluation.
- eval_done  out  1  one-cycle pulse after the last layer completes.
- busy  out  1  high in any state other than IDLE.
- stat_events  out  CNT_W  events evaluated (present only under EVAL_STATS_EN).
- stat_empty_polls  out  CNT_W  pops answered with q_pop_valid=0 (present only under EVAL_STATS_EN).

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; layer counter 0; event register 0; counters 0. An in-flight event is discarded, never replayed.

FSM states: IDLE, POP, WAIT_DATA, EVAL, DONE.
- IDLE: with en=1, go to POP next cycle.
- POP: q_pop=1 for exactly this cycle; next state WAIT_DATA. q_pop is never high outside POP.
- WAIT_DATA: queue answers one cycle after the pop.
  - Capture happens even when en=0.
  - q_pop_valid=1: event_data<=q_data, event_valid<=1, layer counter<=0, go to EVAL.
  - q_pop_valid=0 (queue empty): go to IDLE; increment stat_empty_polls. Empty polling repeats every 3 cycles; this is harmless because a pop on an empty queue does not change the queue.
- EVAL: layer_en = 1 << counter (combinational from the registered counter).
  - layer_stall=1 or en=0: hold counter and layer_en.
  - Otherwise, at counter=NUM_LAYERS-1 go to DONE; else counter+1.
- DONE: eval_done=1 for one cycle; event_valid<=0; increment stat_events; go to IDLE.

Latency and throughput:
- With no stalls, q_data to the first layer_en is 1 cycle.
- Pop to eval_done is NUM_LAYERS+2 cycles.
- Back-to-back events: one event per NUM_LAYERS+4 cycles.

Other rules:
- event_data holds from capture until the next capture; it is not cleared in DONE.
- Counters saturate at all-ones; they never wrap.
- Signed data passes through unmodified; no arithmetic is done on it.
- en=0 in IDLE, POP or DONE: the state is held and the pulse is held.
  - Holding q_pop high in POP re-pops every cycle. To prevent this, q_pop is gated q_pop = (state==POP) & en, and POP advances only when en=1.
  - eval_done is gated the same way.

Optional Feature:
- Macro EVAL_STATS_EN.
- Defined: stat_events and stat_empty_polls exist as ports, behaving as above.
- Undefined: both ports and both counters are absent; all other behaviour is identical.

Decomposition:
- Package eval_sched_pkg holds:
  - the state enum type eval_state_t (IDLE, POP, WAIT_DATA, EVAL, DONE);
  - default constants DATA_W_DEF=64, NUM_LAYERS_DEF=3;
  - a saturating-increment function.
- One sub-module, eval_layer_seq: the layer counter plus one-hot decode with stall/enable hold. Ports: clk, rst, start, adv, last, layer_en.

Test Plan:
1. Reset, then model the queue holding 1, 2, 3; no stalls:
   - Three q_pop pulses.
   - event_data sequence 1, 2, 3.
   - Each event gives layer_en 001, 010, 100 on consecutive cycles, then an eval_done pulse, 5 cycles after its q_pop.
2. Empty queue for 12 cycles after reset:
   - q_pop every 3rd cycle; event_valid stays 0; eval_done never fires.
   - stat_empty_polls=4 (under EVAL_STATS_EN).
3. Event 5 with layer_stall=1 for 2 cycles while layer_en=010:
   - layer_en holds 010 for 3 cycles total.
   - eval_done arrives 2 cycles later than in test 1; event_data stays 5 throughout.
4. en=0 on the cycle after q_pop, q_pop_valid=1, q_data=-7:
   - The event is still captured: event_data=-7.
   - Layer stepping resumes only once en=1.
5. rst asserted during EVAL at layer_en=010 with event 4:
   - All outputs 0 immediately (asynchronously).
   - After release, the next pop takes the next queue entry; event 4 is not re-evaluated.
6. Saturation, with CNT_W forced to 2: 5 events complete -> stat_events reads 3 and stays 3.
